// File: rtl/systolic_pe_simd_pkg.sv
// Shared definitions for the systolic SIMD processing element.
//   SIMD_DUAL / SIMD_WIDE : encodings of simd_mode
//   sext()                : sign-extend the low 'width' bits of a value to 64 bits
//   sat_add()             : signed add with clamp to a 'width'-bit range,
//                           returns {ovf, clamped_sum}
package pe_pkg;

  localparam logic SIMD_DUAL = 1'b0;
  localparam logic SIMD_WIDE = 1'b1;

  // Bits above 'width' are discarded, so this also truncates.
  function automatic logic signed [63:0] sext(input logic [63:0] v, input int width);
    logic signed [63:0] t;
    t = signed'(v << (64 - width));
    return t >>> (64 - width);
  endfunction

  // Operands must already be sign-extended; the 64-bit sum cannot overflow
  // for any width this block is built with.
  function automatic logic [64:0] sat_add(input logic signed [63:0] a,
                                          input logic signed [63:0] b,
                                          input int width);
    logic signed [63:0] s;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    logic               ovf;
    s   = a + b;
    mx  = (64'sd1 <<< (width - 1)) - 64'sd1;
    mn  = -mx - 64'sd1;
    ovf = (s > mx) || (s < mn);
    if (s > mx) s = mx;
    else if (s < mn) s = mn;
    return {ovf, s};
  endfunction

endpackage

// File: rtl/systolic_pe_simd_if.sv
// Bundle of one processing element's non-clock signals.
//   clr, simd_mode                           : control into the PE
//   in_valid/in_data/in_is_weight/in_swap    : token from the west
//   sum_in                                   : partial sum from the north
//   out_valid/out_data/out_is_weight/out_swap: token to the east (1-cycle delay)
//   sum_out/sum_valid                        : partial sum to the south
//   sat_flag                                 : sticky saturation indicator
// Handshake: valid-only, no backpressure. A token is consumed on every rising
// clk edge where in_valid=1; in_data/in_is_weight/in_swap/sum_in are don't-care
// otherwise. sum_valid is high for exactly the cycle after a data beat.
// master = the neighbour/driver side, slave = the PE.
interface systolic_pe_simd_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
);
  logic              clr;
  logic              simd_mode;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_is_weight;
  logic              in_swap;
  logic [ACC_W-1:0]  sum_in;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_is_weight;
  logic              out_swap;
  logic [ACC_W-1:0]  sum_out;
  logic              sum_valid;
  logic              sat_flag;

  modport master (
    output clr, simd_mode, in_valid, in_data, in_is_weight, in_swap, sum_in,
    input  out_valid, out_data, out_is_weight, out_swap, sum_out, sum_valid, sat_flag
  );

  modport slave (
    input  clr, simd_mode, in_valid, in_data, in_is_weight, in_swap, sum_in,
    output out_valid, out_data, out_is_weight, out_swap, sum_out, sum_valid, sat_flag
  );
endinterface

// File: rtl/systolic_pe_simd_mac.sv
// Combinational signed SIMD multiply-accumulate.
//   d, w     : DATA_W operands (two LANE_W lanes in dual mode)
//   acc_in   : ACC_W accumulator (two LACC_W lanes in dual mode)
//   mode     : SIMD_WIDE = one full-width lane, SIMD_DUAL = two independent lanes
//   r        : result, clamped per lane when SAT_EN, wrapped otherwise
//   lane_ovf : per-lane signed overflow (bit 1 always 0 in wide mode)
module simd_mac
  import pe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int SAT_EN = 1
) (
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] w,
  input  logic [ACC_W-1:0]  acc_in,
  input  logic              mode,
  output logic [ACC_W-1:0]  r,
  output logic [1:0]        lane_ovf
);
  localparam int LANE_W = DATA_W / 2;
  localparam int LACC_W = ACC_W / 2;

  logic signed [63:0] p;
  logic signed [63:0] a;
  logic [64:0]        s;

  always_comb begin
    r        = '0;
    lane_ovf = '0;
    p        = '0;
    a        = '0;
    s        = '0;
    if (mode == SIMD_WIDE) begin
      // Product is reduced to ACC_W before the add, as the lane adder sees it.
      p = sext(sext(64'(d), DATA_W) * sext(64'(w), DATA_W), ACC_W);
      a = sext(64'(acc_in), ACC_W);
      s = sat_add(p, a, ACC_W);
      lane_ovf[0] = s[64];
      r = (SAT_EN != 0) ? s[ACC_W-1:0] : ACC_W'(p + a);
    end else begin
      // Each lane is computed in isolation, so no carry can cross lanes.
      for (int i = 0; i < 2; i++) begin
        p = sext(sext(64'(d[i*LANE_W +: LANE_W]), LANE_W) *
                 sext(64'(w[i*LANE_W +: LANE_W]), LANE_W), LACC_W);
        a = sext(64'(acc_in[i*LACC_W +: LACC_W]), LACC_W);
        s = sat_add(p, a, LACC_W);
        lane_ovf[i] = s[64];
        r[i*LACC_W +: LACC_W] = (SAT_EN != 0) ? s[LACC_W-1:0] : LACC_W'(p + a);
      end
    end
  end
endmodule

// File: rtl/systolic_pe_simd.sv
// Weight-stationary systolic PE with double-buffered weight and SIMD MAC.
//   clk, rst_n : clock, asynchronous active-low reset
//   pe         : systolic_pe_simd_if.slave (control, west/north inputs,
//                east/south outputs, sat_flag)
// Tokens pass east and sums pass south through one register each. Weights
// load into a shadow register; a swap token copies shadow -> active as the
// wavefront passes, so weights change without stalling the data stream.
module systolic_pe_simd
  import pe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int SAT_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  systolic_pe_simd_if.slave  pe
);
  logic [DATA_W-1:0] w_act;
  logic [DATA_W-1:0] w_shd;
  logic [ACC_W-1:0]  mac_r;
  logic [1:0]        mac_ovf;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_is_weight_q;
  logic              out_swap_q;
  logic [ACC_W-1:0]  sum_out_q;
  logic              sum_valid_q;
  logic              sat_flag_q;

  simd_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SAT_EN (SAT_EN)
  ) u_mac (
    .d        (pe.in_data),
    .w        (w_act),
    .acc_in   (pe.sum_in),
    .mode     (pe.simd_mode),
    .r        (mac_r),
    .lane_ovf (mac_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_act           <= '0;
      w_shd           <= '0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_is_weight_q <= 1'b0;
      out_swap_q      <= 1'b0;
      sum_out_q       <= '0;
      sum_valid_q     <= 1'b0;
      sat_flag_q      <= 1'b0;
    end else if (pe.clr) begin
      w_act           <= '0;
      w_shd           <= '0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_is_weight_q <= 1'b0;
      out_swap_q      <= 1'b0;
      sum_out_q       <= '0;
      sum_valid_q     <= 1'b0;
      sat_flag_q      <= 1'b0;
    end else begin
      // East pass is unconditional so neighbours see the exact token stream.
      out_valid_q     <= pe.in_valid;
      out_data_q      <= pe.in_data;
      out_is_weight_q <= pe.in_is_weight;
      out_swap_q      <= pe.in_swap;
      sum_valid_q     <= 1'b0;
      if (pe.in_valid) begin
        // Non-blocking reads give the old shadow / old active weight when a
        // swap shares a beat with a load or a data token.
        if (pe.in_swap) w_act <= w_shd;
        if (pe.in_is_weight) begin
          w_shd <= pe.in_data;
        end else begin
          sum_out_q   <= mac_r;
          sum_valid_q <= 1'b1;
          if ((SAT_EN != 0) && (mac_ovf != 2'b00)) sat_flag_q <= 1'b1;
        end
      end
    end
  end

  assign pe.out_valid     = out_valid_q;
  assign pe.out_data      = out_data_q;
  assign pe.out_is_weight = out_is_weight_q;
  assign pe.out_swap      = out_swap_q;
  assign pe.sum_out       = sum_out_q;
  assign pe.sum_valid     = sum_valid_q;
  assign pe.sat_flag      = sat_flag_q;
endmodule
